// File: rtl/ha_array_product_reducer.sv
// Final reduction of an 8x8 half-adder array into a clamped 16-bit product.
// Two register stages (row values, then clamped sum) share a single global stall.
module ha_array_product_reducer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [8:0]  ha_array_0_t,
    input  logic [8:0]  ha_array_1_t,
    input  logic [8:0]  ha_array_2_t,
    input  logic [8:0]  ha_array_3_t,
    input  logic [6:0]  ha_array_0_b,
    input  logic [6:0]  ha_array_1_b,
    input  logic [6:0]  ha_array_2_b,
    input  logic [6:0]  ha_array_3_b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] product,
    output logic        sat,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] sat_count
);

    logic [8:0]  top_vec [4];
    logic [6:0]  bot_vec [4];
    logic [9:0]  row_next [4];
    logic [9:0]  row_q [4];
    logic        s1_valid;
    logic        advance;
    logic [16:0] sum_s;
    logic        sat_next;
    logic [15:0] product_next;

    assign top_vec[0] = ha_array_0_t;
    assign top_vec[1] = ha_array_1_t;
    assign top_vec[2] = ha_array_2_t;
    assign top_vec[3] = ha_array_3_t;
    assign bot_vec[0] = ha_array_0_b;
    assign bot_vec[1] = ha_array_1_b;
    assign bot_vec[2] = ha_array_2_b;
    assign bot_vec[3] = ha_array_3_b;

    // Bottom vectors sit two bit positions above their top vector.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            row_next[k] = {1'b0, top_vec[k]} + {1'b0, bot_vec[k], 2'b00};
        end
    end

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                for (int k = 0; k < 4; k++) begin
                    row_q[k] <= row_next[k];
                end
            end
        end
    end

    // Max sum is 86615, so bit 16 alone flags overflow of the 16-bit result.
    always_comb begin
        sum_s = {7'b0, row_q[0]}
              + {5'b0, row_q[1], 2'b00}
              + {3'b0, row_q[2], 4'b0000}
              + {1'b0, row_q[3], 6'b000000};
        sat_next     = sum_s[16];
        product_next = sat_next ? 16'hFFFF : sum_s[15:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            product   <= 16'h0000;
            sat       <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                product <= product_next;
                sat     <= sat_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_count <= 16'h0000;
        end else if (out_valid && out_ready && sat && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_ha_array_product_reducer.sv
// Bench for ha_array_product_reducer: directed and random stimulus scored against
// a bit-weight reference model and an ideal two-deep pipeline with global stall.
module tb_ha_array_product_reducer;

    logic        clk;
    logic        rst_n;
    logic [8:0]  t_vec [4];
    logic [6:0]  b_vec [4];
    logic        in_valid;
    logic        in_ready;
    logic [15:0] product;
    logic        sat;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sat_count;

    int          num_asserts;
    int          num_fails;
    int          delivered;

    logic        m_valid [2];
    logic [16:0] m_sum [2];
    logic [15:0] m_sat_count;

    ha_array_product_reducer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ha_array_0_t (t_vec[0]),
        .ha_array_1_t (t_vec[1]),
        .ha_array_2_t (t_vec[2]),
        .ha_array_3_t (t_vec[3]),
        .ha_array_0_b (b_vec[0]),
        .ha_array_1_b (b_vec[1]),
        .ha_array_2_b (b_vec[2]),
        .ha_array_3_b (b_vec[3]),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .product      (product),
        .sat          (sat),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .sat_count    (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sum of individual bit weights: top bit i of row k weighs 2^(2k+i), bottom 2^(2k+i+2).
    function automatic logic [16:0] ref_sum();
        int unsigned s;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 9; i++) if (t_vec[k][i]) s += (1 << (2 * k + i));
            for (int i = 0; i < 7; i++) if (b_vec[k][i]) s += (1 << (2 * k + i + 2));
        end
        return s[16:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_asserts++;
        assert (observed === expected)
        else begin
            num_fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic set_arrays(input logic [8:0] t, input logic [6:0] b);
        for (int k = 0; k < 4; k++) begin
            t_vec[k] = t;
            b_vec[k] = b;
        end
    endtask

    task automatic set_random_arrays();
        for (int k = 0; k < 4; k++) begin
            t_vec[k] = 9'($urandom_range(0, 511));
            b_vec[k] = 7'($urandom_range(0, 127));
        end
    endtask

    // Each row carries x times a two-bit slice of y, split between the top and bottom vector.
    task automatic set_from_operands(input int unsigned x, input int unsigned y);
        int unsigned v;
        int unsigned bv;
        for (int k = 0; k < 4; k++) begin
            v  = x * ((y >> (2 * k)) & 3);
            bv = (v >> 2) > 127 ? 127 : (v >> 2);
            b_vec[k] = 7'(bv);
            t_vec[k] = 9'(v - 4 * bv);
        end
    endtask

    // Drive one cycle at the falling edge, check before the rising edge, then step the model.
    task automatic applyStimulus(input logic iv, input logic ordy, output logic accepted);
        logic adv;
        in_valid  = iv;
        out_ready = ordy;
        #1;
        checkOutput("out_valid", {31'b0, out_valid}, {31'b0, m_valid[1]});
        checkOutput("in_ready", {31'b0, in_ready}, {31'b0, (!m_valid[1] || ordy)});
        if (m_valid[1]) begin
            checkOutput("product", {16'b0, product},
                        (m_sum[1] > 17'd65535) ? 32'h0000FFFF : {15'b0, m_sum[1]});
            checkOutput("sat", {31'b0, sat}, {31'b0, (m_sum[1] > 17'd65535)});
        end
        checkOutput("sat_count", {16'b0, sat_count}, {16'b0, m_sat_count});
        @(posedge clk);
        adv      = !m_valid[1] || ordy;
        accepted = 1'b0;
        if (!rst_n) begin
            m_valid[0]  = 1'b0;
            m_valid[1]  = 1'b0;
            m_sat_count = 16'h0000;
        end else begin
            if (m_valid[1] && ordy) begin
                delivered++;
                if ((m_sum[1] > 17'd65535) && (m_sat_count != 16'hFFFF)) m_sat_count++;
            end
            if (adv) begin
                m_valid[1] = m_valid[0];
                m_sum[1]   = m_sum[0];
                m_valid[0] = iv;
                m_sum[0]   = ref_sum();
                accepted   = iv;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic acc;
        int   acc_cnt;
        int   cyc;
        int   base;

        num_asserts = 0;
        num_fails   = 0;
        delivered   = 0;
        m_valid[0]  = 1'b0;
        m_valid[1]  = 1'b0;
        m_sum[0]    = '0;
        m_sum[1]    = '0;
        m_sat_count = 16'h0000;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        set_arrays(9'h000, 7'h00);

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, acc);
        checkOutput("rst_product", {16'b0, product}, 32'h0);
        checkOutput("rst_sat", {31'b0, sat}, 32'h0);
        rst_n = 1'b1;

        $display("[TB] zero operand pulse");
        set_arrays(9'h000, 7'h00);
        applyStimulus(1'b1, 1'b1, acc);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, acc);

        $display("[TB] single bit inputs");
        set_arrays(9'h000, 7'h00);
        t_vec[0] = 9'h001;
        applyStimulus(1'b1, 1'b1, acc);
        set_arrays(9'h000, 7'h00);
        t_vec[3] = 9'h100;
        applyStimulus(1'b1, 1'b1, acc);
        set_arrays(9'h000, 7'h00);
        b_vec[1] = 7'h01;
        applyStimulus(1'b1, 1'b1, acc);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, acc);

        $display("[TB] all ones saturates");
        set_arrays(9'h1FF, 7'h7F);
        applyStimulus(1'b1, 1'b1, acc);
        set_arrays(9'h000, 7'h00);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, acc);
        checkOutput("sat_count_one", {16'b0, sat_count}, 32'd1);

        $display("[TB] stream of eight with stall");
        base    = delivered;
        acc_cnt = 0;
        cyc     = 0;
        set_random_arrays();
        while (acc_cnt < 8 && cyc < 50) begin
            applyStimulus(1'b1, !(cyc >= 3 && cyc <= 6), acc);
            if (acc) begin
                acc_cnt++;
                set_random_arrays();
            end
            cyc++;
        end
        checkOutput("stream_accepted", acc_cnt, 8);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, acc);
        checkOutput("stream_delivered", delivered - base, 8);

        $display("[TB] reset with results in flight");
        set_arrays(9'h1FF, 7'h7F);
        applyStimulus(1'b1, 1'b1, acc);
        set_random_arrays();
        applyStimulus(1'b1, 1'b1, acc);
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b1, acc);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, acc);
        checkOutput("rst_flush_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("rst_sat_count", {16'b0, sat_count}, 32'h0);
        set_from_operands(200, 100);
        applyStimulus(1'b1, 1'b1, acc);
        set_arrays(9'h000, 7'h00);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, acc);

        $display("[TB] random operand products");
        for (int i = 0; i < 60; i++) begin
            set_from_operands($urandom_range(0, 255), $urandom_range(0, 255));
            applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), acc);
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, acc);

        $display("[TB] random array vectors");
        for (int i = 0; i < 60; i++) begin
            set_random_arrays();
            applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), acc);
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, acc);

        $display("End of test - %0d assertions evaluated, %0d failures", num_asserts, num_fails);
        $finish;
    end

endmodule

// File: doc/ha_array_product_reducer.md
HA_ARRAY_PRODUCT_REDUCER -- requirements
Module: ha_array_product_reducer

Interface
REQ-001: The module SHALL have one clock and a synchronous, active-low reset; all state changes SHALL occur on the rising edge of clk.
REQ-002: clk  input  1  sole clock.
REQ-003: rst_n  input  1  synchronous active-low reset, sampled on the rising clk edge.
REQ-004: ha_array_k_t, k=0..3  input  9 each  top vectors from the 8x8 half-adder-array stage.
REQ-005: ha_array_k_b, k=0..3  input  7 each  bottom vectors from the 8x8 half-adder-array stage.
REQ-006: in_valid  input  1  the eight array vectors are valid this cycle.
REQ-007: in_ready  output  1  the block accepts input this cycle.
REQ-008: product  output  16  reduced unsigned product.
REQ-009: sat  output  1  product was clamped for this result.
REQ-010: out_valid  output  1  product and sat are valid.
REQ-011: out_ready  input  1  the downstream stage accepts the result.
REQ-012: sat_count  output  16  number of saturated results delivered since reset.

Function
REQ-013: Bit weights SHALL be: ha_array_k_t[i] = 2^(2k+i); ha_array_k_b[i] = 2^(2k+i+2).
REQ-014: Row value row_k SHALL be ha_array_k_t + (ha_array_k_b << 2), computed as a 10-bit unsigned value (max 1019).
REQ-015: The sum SHALL be S = row_0 + (row_1<<2) + (row_2<<4) + (row_3<<6), held at 17 bits with no truncation.
REQ-016: If S > 65535, product SHALL be 0xFFFF and sat SHALL be 1; otherwise product SHALL be S[15:0] and sat SHALL be 0.
REQ-017: The pipeline SHALL have two register stages.
  - S1: registers the four row values plus a valid bit.
  - S2: registers product, sat and out_valid.
REQ-018: Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-019: Latency SHALL be exactly 2 cycles from input transfer to out_valid, absent stalls; throughput SHALL be 1 result per cycle while out_ready=1.
REQ-020: Global stall: advance = !out_valid || out_ready; in_ready SHALL equal advance (combinational, no dependence on in_valid).
REQ-021: When advance=0, both stages SHALL hold their contents; product and sat SHALL be stable while out_valid=1 and out_ready=0.
REQ-022: Bubbles SHALL propagate as cleared valid bits, so an empty S2 is refilled on the next advance.
REQ-023: sat_count SHALL increment by 1 on each output transfer with sat=1.
REQ-024: sat_count SHALL saturate at 0xFFFF and never wrap.
REQ-025: Input data SHALL be ignored when in_valid=0; a simultaneous input transfer and output transfer in the same cycle SHALL be supported with no loss or duplication.

Reset
REQ-026: While rst_n=0 at a clk edge, all of the following SHALL clear: S1 valid, out_valid, product, sat and sat_count.
REQ-027: While reset is asserted, in_ready SHALL be 1, because out_valid=0.
REQ-028: Reset asserted mid-operation SHALL discard all in-flight results; out_valid SHALL be 0 in the first cycle after the reset edge.

Verification
REQ-029: All array inputs 0, in_valid pulsed 1 cycle, out_ready=1 -> two cycles later: out_valid=1 for 1 cycle, product=0x0000, sat=0.
REQ-030: Single bits, one transfer each, out_ready=1:
  - ha_array_0_t=1 -> product=0x0001.
  - ha_array_3_t[8]=1 -> product=0x4000.
  - ha_array_1_b[0]=1 -> product=0x0010.
REQ-031: All inputs all-ones (S=86615) -> product=0xFFFF, sat=1, and sat_count increments to 1 on the transfer.
REQ-032: Back-to-back stream of 8 inputs with out_ready held 0 for cycles 3-6 -> all 8 results delivered in order with correct values, in_ready=0 while stalled, and no result duplicated or dropped.
REQ-033: rst_n=0 for 1 cycle while 2 results are in flight -> no out_valid from those results, sat_count=0, and the next input completes with 2-cycle latency.
REQ-034: Random compliance: for each random 8x8 x,y pair, drive the arrays from the upstream half-adder-array stage; product SHALL equal the reference model of REQ-013 to REQ-016.
